// File: rtl/motor_pwm.sv
// motor_pwm: single-channel PWM motor driver with direction-reversal blanking.
// A signed 16-bit speed command is turned into a duty count (saturated to
// PWM_TOP) and a direction bit. Duty only changes at the period wrap, and a
// change of direction passes through a DEAD interval of DEAD_CYC cycles with
// pwm held low. All outputs are registered.
// Optional feature: define MOTOR_PWM_DEADBAND_EN to force commands whose
// magnitude is below DEADBAND to duty 0 with the direction held.
module motor_pwm #(
    parameter int PWM_TOP  = 1000,
    parameter int DEAD_CYC = 20,
    parameter int DEADBAND = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] Motor,
    input  logic        motor_vld,
    output logic        pwm,
    output logic        dir,
    output logic        period_start,
    output logic [15:0] duty
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(PWM_TOP - 1);
    localparam logic [16:0] TOP_MAG   = 17'(PWM_TOP);
    localparam logic [7:0]  DEAD_LAST = 8'(DEAD_CYC - 1);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [7:0]  dead_cnt, dead_d;
    logic [15:0] cmd_reg, cmd_d;
    logic [15:0] duty_d;
    logic        dir_d;
    logic        pwm_d;
    logic        start_d;

    // Command evaluation signals
    logic [15:0] cmd_eff;
    logic [16:0] cmd_ext;
    logic [16:0] mag;
    logic [15:0] duty_req;
    logic        dir_req;
    logic        wrap;

    // Turn the effective command (a same-cycle capture wins) into a requested duty and direction
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cmd_eff  = motor_vld ? Motor : cmd_reg;
        cmd_ext  = {cmd_eff[15], cmd_eff};
        mag      = cmd_eff[15] ? (17'd0 - cmd_ext) : cmd_ext;
        duty_req = (mag > TOP_MAG) ? TOP_MAG[15:0] : mag[15:0];
        dir_req  = (cmd_eff == 16'd0) ? dir : ~cmd_eff[15];
`ifdef MOTOR_PWM_DEADBAND_EN
        if (mag < 17'(DEADBAND)) begin
            duty_req = 16'd0;
            dir_req  = dir;
        end
`endif
    end

    assign wrap = (cnt == CNT_LAST);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            dead_cnt     <= 8'd0;
            cmd_reg      <= 16'd0;
            duty         <= 16'd0;
            dir          <= 1'b1;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            dead_cnt     <= dead_d;
            cmd_reg      <= cmd_d;
            duty         <= duty_d;
            dir          <= dir_d;
            pwm          <= pwm_d;
            period_start <= start_d;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dead_d  = dead_cnt;
        duty_d  = duty;
        dir_d   = dir;
        cmd_d   = cmd_eff;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            dead_d  = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = RUN;
                    cnt_d   = 16'd0;
                    duty_d  = duty_req;
                    dir_d   = dir_req;
                end
                RUN: begin
                    if (wrap) begin
                        cnt_d = 16'd0;
                        if (dir_req != dir) begin
                            state_d = DEAD;
                            dead_d  = 8'd0;
                        end else begin
                            duty_d = duty_req;
                        end
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        state_d = RUN;
                        dead_d  = 8'd0;
                        cnt_d   = 16'd0;
                        dir_d   = ~dir;
                        duty_d  = duty_req;
                    end else begin
                        dead_d = dead_cnt + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    dead_d  = 8'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with cnt
    always_comb begin
        pwm_d   = (state_d == RUN) && (cnt_d < duty_d);
        start_d = (state_d == RUN) && (cnt_d == 16'd0);
    end

endmodule

// File: doc/motor_pwm.md
MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 SHALL have parameter PWM_TOP, default 1000: PWM period in clk cycles; legal range 2..32767.
REQ-002 SHALL have parameter DEAD_CYC, default 20: length of the direction-reversal blanking interval in clk cycles; legal range 1..255.
REQ-003 SHALL have parameter DEADBAND, default 50: magnitude threshold, used only with the Configuration feature.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: run request.
REQ-007 SHALL have port Motor, input, 16 bits: signed two's-complement speed command from the control stage.
REQ-008 SHALL have port motor_vld, input, 1 bit: Motor is sampled in any cycle where motor_vld=1.
REQ-009 SHALL have port pwm, output, 1 bit: registered PWM drive.
REQ-010 SHALL have port dir, output, 1 bit: registered direction; 1 = forward, 0 = reverse.
REQ-011 SHALL have port period_start, output, 1 bit: one-cycle pulse at the start of each PWM period in RUN.
REQ-012 SHALL have port duty, output, 16 bits: unsigned duty count currently in effect.

Function
REQ-013 SHALL capture Motor into cmd_reg on every cycle with motor_vld=1; when several captures occur within one period, the last one wins.
REQ-014 SHALL form the magnitude as |cmd_reg|, with -32768 treated as 32768, and saturate the magnitude to PWM_TOP.
REQ-015 SHALL set the requested direction to 1 for a positive command, 0 for a negative command, and the current dir for a zero command.
REQ-016 SHALL implement the states IDLE, RUN and DEAD.
REQ-017 In IDLE, pwm=0, cnt=0 and period_start=0; when enable=1, the block SHALL enter RUN with cnt=0 and load duty and dir from cmd_reg.
REQ-018 In RUN, cnt SHALL count 0..PWM_TOP-1 and wrap to 0; pwm SHALL be 1 when cnt < duty; period_start SHALL be 1 when cnt==0.
REQ-019 SHALL update duty only at the wrap (cnt==PWM_TOP-1), so a period never changes duty mid-way.
REQ-020 At the wrap, if the requested direction differs from dir, the block SHALL enter DEAD instead of loading duty.
REQ-021 In DEAD, pwm SHALL be 0 for exactly DEAD_CYC cycles; the block SHALL then flip dir, load duty, set cnt=0 and return to RUN.
REQ-022 A command sign change that arrives during DEAD SHALL be evaluated at the next wrap.
REQ-023 If enable=0 in any state, the block SHALL enter IDLE on the next edge with pwm=0; dir and cmd_reg are held.
REQ-024 duty=0 SHALL yield pwm constantly 0; duty=PWM_TOP SHALL yield pwm constantly 1 in RUN.
REQ-025 A simultaneous motor_vld and wrap SHALL use the value captured in that same cycle at the wrap.

Reset
REQ-026 With rst=1, the block SHALL go to state IDLE with cnt=0, cmd_reg=0, duty=0, pwm=0, dir=1, period_start=0 and the dead counter at 0.
REQ-027 rst SHALL take priority over enable and motor_vld.
REQ-028 rst asserted mid-RUN or mid-DEAD SHALL take effect on the next edge.

Configuration
REQ-029 SHALL support the macro MOTOR_PWM_DEADBAND_EN.
REQ-030 With MOTOR_PWM_DEADBAND_EN defined, a magnitude below DEADBAND SHALL be forced to duty 0 with direction held, and any other magnitude SHALL be used unchanged.
REQ-031 Without MOTOR_PWM_DEADBAND_EN, there SHALL be no deadband logic and the magnitude SHALL be used directly.

Verification
REQ-032 Reset then enable with Motor=+300 (vld): dir=1, period_start every 1000 cycles, pwm high 300 and low 700 cycles each period.
REQ-033 Motor=+300 then -500 mid-period: current period completes at 300; pwm=0 for 20 cycles; dir=0; following periods high for 500 cycles.
REQ-034 Motor=+5000 gives pwm constantly 1 with duty=1000; Motor=-32768 gives duty=1000, dir=0 after the DEAD interval.
REQ-035 Motor=+30 with MOTOR_PWM_DEADBAND_EN defined: duty=0, pwm=0, dir unchanged; without the macro: high 30 cycles per period.
REQ-036 enable dropped at cnt=150, then raised 10 cycles later: pwm=0 the next cycle; on re-enable cnt restarts at 0 and period_start pulses; rst=1 at cnt=400 returns all outputs to reset values on the next edge.
